// File: rtl/rst_pkg.sv
// Shared definitions for the reset sequencer: FSM states, reset-cause codes
// and the counter-width helper.
package rst_pkg;

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_LOCKWAIT = 2'd1,
        ST_RELEASE  = 2'd2,
        ST_RUN      = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_EXT  = 2'd0;
    localparam logic [1:0] CAUSE_SOFT = 2'd1;
    localparam logic [1:0] CAUSE_LOCK = 2'd2;

    // Width able to hold the value 'limit' itself.
    function automatic int cnt_width(input int limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Flop chain that brings an asynchronous level into the clk domain.
// The asynchronous clear forces the chain output low immediately.
module rst_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] stages;

    // Shift the input through STAGES flops; clear asynchronously.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour, giving a true shift register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[STAGES-2:0], din};
        end
    end

    assign dout = stages[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel reset generator: asserts all channel resets together
// (asynchronously via rst_in_n, or on the next edge for soft/lock aborts)
// and releases them one by one, STEP cycles apart, once the PLL is stable.
module reset_sequencer
    import rst_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int LOCK_FILT   = 16,
    parameter int STEP        = 16
) (
    input  logic           clk,
    input  logic           rst_in_n,
    input  logic           pll_locked,
    input  logic           soft_rst_req,
    output logic [NCH-1:0] rst_out_n,
    output logic           seq_done,
    output logic [1:0]     rst_cause
);

    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam int LW = cnt_width(LOCK_FILT);
    localparam int SW = cnt_width(STEP);
    localparam int CW = cnt_width(NCH);

    logic          rst_sync;
    logic          lock_s;
    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [LW-1:0] lock_cnt;
    logic [SW-1:0] step_cnt;
    logic [CW-1:0] ch_idx;
    logic          abort;
    logic [1:0]    abort_cause;

    rst_sync_chain #(.STAGES(SYNC_STAGES)) u_rst_sync (
        .clk   (clk),
        .clr_n (rst_in_n),
        .din   (1'b1),
        .dout  (rst_sync)
    );

    rst_sync_chain #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clk),
        .clr_n (rst_in_n),
        .din   (pll_locked),
        .dout  (lock_s)
    );

    // Decide whether this cycle aborts back to HOLD; soft beats lock loss.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        abort       = 1'b0;
        abort_cause = CAUSE_SOFT;
        if (state != ST_HOLD) begin
            if (soft_rst_req) begin
                abort = 1'b1;
            end else if (!lock_s && (state == ST_RELEASE || state == ST_RUN)) begin
                abort       = 1'b1;
                abort_cause = CAUSE_LOCK;
            end
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state     <= ST_HOLD;
            hold_cnt  <= '0;
            lock_cnt  <= '0;
            step_cnt  <= '0;
            ch_idx    <= '0;
            rst_out_n <= '0;
            seq_done  <= 1'b0;
            rst_cause <= CAUSE_EXT;
        end else if (abort) begin
            // Re-enter HOLD with hold_cnt at 0 so the full minimum hold applies.
            state     <= ST_HOLD;
            hold_cnt  <= '0;
            lock_cnt  <= '0;
            step_cnt  <= '0;
            ch_idx    <= '0;
            rst_out_n <= '0;
            seq_done  <= 1'b0;
            rst_cause <= abort_cause;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (soft_rst_req) begin
                        hold_cnt <= '0;
                    end else if (rst_sync) begin
                        if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                            hold_cnt <= '0;
                            lock_cnt <= '0;
                            state    <= ST_LOCKWAIT;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                ST_LOCKWAIT: begin
                    if (!lock_s) begin
                        lock_cnt <= '0;
                    end else if (lock_cnt == LW'(LOCK_FILT - 1)) begin
                        lock_cnt <= '0;
                        step_cnt <= '0;
                        ch_idx   <= '0;
                        state    <= ST_RELEASE;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (step_cnt == SW'(STEP - 1)) begin
                        step_cnt <= '0;
                        // Shifting a one in from bit 0 releases channels strictly in order.
                        rst_out_n <= (rst_out_n << 1) | NCH'(1);
                        if (ch_idx == CW'(NCH - 1)) begin
                            state    <= ST_RUN;
                            seq_done <= 1'b1;
                        end else begin
                            ch_idx <= ch_idx + 1'b1;
                        end
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    seq_done <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios followed by
// randomized soft/lock/async-reset activity, all compared every cycle
// against a counter-based behavioural model.
module tb_reset_sequencer;

    localparam int NCH  = 4;
    localparam int SYNC = 2;
    localparam int HOLD = 16;
    localparam int LOCK = 16;
    localparam int STEP = 16;

    logic           clk = 1'b0;
    logic           rst_in_n;
    logic           pll_locked;
    logic           soft_rst_req;
    logic [NCH-1:0] rst_out_n;
    logic           seq_done;
    logic [1:0]     rst_cause;

    int n_vec = 0;
    int n_bad = 0;

    // Model: qualifying hold cycles, consecutive lock cycles, release elapsed.
    int              m_hold;
    int              m_lock;
    int              m_rel;
    logic [1:0]      m_cause;
    logic [SYNC-1:0] m_rs;
    logic [SYNC-1:0] m_lk;

    reset_sequencer #(
        .NCH(NCH), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD),
        .LOCK_FILT(LOCK), .STEP(STEP)
    ) dut (
        .clk          (clk),
        .rst_in_n     (rst_in_n),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .rst_out_n    (rst_out_n),
        .seq_done     (seq_done),
        .rst_cause    (rst_cause)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_obs();
        return 32'({rst_out_n, seq_done, rst_cause});
    endfunction

    // Released channels = whole STEP periods elapsed since release began.
    function automatic logic [31:0] model_out();
        logic [NCH-1:0] o;
        int n;
        n = m_rel / STEP;
        o = '0;
        for (int i = 0; i < NCH; i++) o[i] = (i < n);
        return 32'({o, (m_rel == NCH * STEP), m_cause});
    endfunction

    task automatic model_reset();
        m_hold  = 0;
        m_lock  = 0;
        m_rel   = 0;
        m_cause = 2'd0;
        m_rs    = '0;
        m_lk    = '0;
    endtask

    // One clock edge of the reference: uses synchronised values from before the edge.
    task automatic model_step();
        logic rs;
        logic ls;
        rs = m_rs[SYNC-1];
        ls = m_lk[SYNC-1];
        if (m_hold < HOLD) begin
            if (soft_rst_req) m_hold = 0;
            else if (rs) m_hold++;
        end else if (soft_rst_req) begin
            m_cause = 2'd1;
            m_hold = 0; m_lock = 0; m_rel = 0;
        end else if (!ls && m_lock == LOCK) begin
            m_cause = 2'd2;
            m_hold = 0; m_lock = 0; m_rel = 0;
        end else if (!ls) begin
            m_lock = 0;
        end else if (m_lock < LOCK) begin
            m_lock++;
        end else if (m_rel < NCH * STEP) begin
            m_rel++;
        end
        m_rs = {m_rs[SYNC-2:0], 1'b1};
        m_lk = {m_lk[SYNC-2:0], pll_locked};
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("cycle", dut_obs(), model_out());
    endtask

    // Called at a falling clk edge: short rst_in_n pulse fully between rising edges.
    task automatic async_pulse();
        #1 rst_in_n = 1'b0;
        #1 check("async_assert", dut_obs(), 32'd0);
        model_reset();
        #2 rst_in_n = 1'b1;
    endtask

    task automatic cycles_to_release(input int ch, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (rst_out_n[ch] !== 1'b1 && n < 400);
    endtask

    initial begin
        int t_base;
        int n;
        rst_in_n     = 1'b1;
        pll_locked   = 1'b1;
        soft_rst_req = 1'b0;
        model_reset();
        #2 rst_in_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", dut_obs(), 32'd0);
        #4 rst_in_n = 1'b1;

        // Power-up, lock present throughout.
        cycles_to_release(0, t_base);
        check("powerup_first_release", 32'(t_base), 32'(SYNC + HOLD + LOCK + STEP));
        for (int k = 1; k < NCH; k++) begin
            cycles_to_release(k, n);
            check("release_gap", 32'(n), 32'(STEP));
        end
        check("seq_done_run", 32'(seq_done), 32'd1);
        check("powerup_cause", 32'(rst_cause), 32'd0);

        // Asynchronous pulse in mid-RELEASE repeats the power-up timing.
        repeat (5) tick();
        async_pulse();
        repeat (60) tick();
        async_pulse();
        cycles_to_release(0, n);
        check("repulse_release", 32'(n), 32'(t_base));
        repeat (60) tick();

        // Soft reset held for 5 cycles in RUN.
        soft_rst_req = 1'b1;
        tick();
        check("soft_cause", 32'(rst_cause), 32'd1);
        check("soft_outputs", 32'(rst_out_n), 32'd0);
        repeat (4) tick();
        soft_rst_req = 1'b0;
        cycles_to_release(0, n);
        check("soft_to_release", 32'(n), 32'(HOLD + LOCK + STEP));
        repeat (60) tick();

        // One-cycle lock glitch seen in LOCKWAIT with 10 counts accumulated.
        async_pulse();
        repeat (26) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        cycles_to_release(0, n);
        check("lock_glitch_slip", 32'(n + 27), 32'(t_base + 11));
        check("glitch_cause", 32'(rst_cause), 32'd0);
        repeat (60) tick();

        // Lock loss in RUN, parked in LOCKWAIT while the PLL stays unlocked.
        pll_locked = 1'b0;
        repeat (4) tick();
        check("lockloss_cause", 32'(rst_cause), 32'd2);
        repeat (40) tick();
        check("lockloss_park", 32'({rst_out_n, seq_done}), 32'd0);
        pll_locked = 1'b1;
        repeat (90) tick();
        check("lockloss_recover", 32'(seq_done), 32'd1);

        // Soft request and lock loss observed on the same edge in RELEASE.
        async_pulse();
        repeat (55) tick();
        pll_locked = 1'b0;
        repeat (2) tick();
        soft_rst_req = 1'b1;
        tick();
        check("soft_over_lock", 32'(rst_cause), 32'd1);
        pll_locked = 1'b1;
        repeat (2) tick();
        soft_rst_req = 1'b0;
        cycles_to_release(0, n);
        check("soft_lock_release", 32'(n), 32'(HOLD + LOCK + STEP));
        repeat (60) tick();

        // Randomized activity.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) < 4) async_pulse();
            if (soft_rst_req) begin
                if ($urandom_range(0, 3) == 0) soft_rst_req = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                soft_rst_req = 1'b1;
            end
            if (pll_locked) begin
                if ($urandom_range(0, 399) == 0) pll_locked = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                pll_locked = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
